fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction-fetch front end of the core. Generates sequential fetch addresses and issues them to instruction memory over a valid/ready request channel.
- Buffers in-order responses and hands {pc, instruction} to decode.
- Consumes the taken-branch/jump redirect (b_taken, b_pc) produced by the branch unit in execute, and discards every wrong-path fetch still in flight or buffered.

Parameters:
- RESET_PC, 32'h0000_0000: first fetch address after reset.
- BUF_DEPTH, 2: maximum outstanding requests plus buffered instructions; power of two, ≥2.

Ports:
- i_clk  input  1  clock, all state updates on the rising edge.
- i_rst_n  input  1  asynchronous, active-low reset.
- o_imem_req_valid  output  1  fetch request valid.
- i_imem_req_ready  input  1  memory accepts the request this cycle.
- o_imem_req_addr  output  32  fetch address, always 4-byte aligned.
- i_imem_rsp_valid  input  1  response valid; one response per accepted request, in order, earliest 1 cycle after acceptance.
- i_imem_rsp_data  input  32  fetched instruction word.
- i_b_taken  input  1  redirect strobe from the branch unit, sampled every cycle.
- i_b_pc  input  32  redirect target.
- o_valid  output  1  instruction available to decode.
- o_instr  output  32  instruction word (32'h0000_0013 NOP when o_valid=0).
- o_pc  output  32  address of o_instr.
- i_ready  input  1  decode consumes the instruction when o_valid & i_ready.
- o_misaligned  output  1  one-cycle pulse: redirect target had b_pc[1:0] != 0.

Behaviour:
Reset (async assert):
- fetch_pc=RESET_PC; outstanding=0; drop_cnt=0; buffer empty; state=S_BOOT.
- Outputs: o_imem_req_valid=0, o_valid=0, o_instr=32'h13, o_pc=0, o_misaligned=0.
- Reset asserted mid-operation abandons all in-flight requests. Memory is reset together with this block.

States:
- S_BOOT: one cycle after reset release, no request → S_RUN.
- S_RUN: drop_cnt==0.
- S_DRAIN: drop_cnt>0.
- S_RUN→S_DRAIN on redirect with outstanding>0, counting requests accepted that same cycle. S_DRAIN→S_RUN when drop_cnt reaches 0.
- Redirect in S_DRAIN adds the new in-flight count: drop_cnt becomes total outstanding after that edge.

Request:
- o_imem_req_valid = (state!=S_BOOT) & (outstanding + occupancy < BUF_DEPTH). Requests are also issued in S_DRAIN.
- o_imem_req_addr = fetch_pc.
- On handshake: fetch_pc += 4 (wraps modulo 2^32); push the address into the in-flight PC queue; outstanding++.
- Once asserted, valid and addr stay stable until ready, unless a redirect occurs. A redirect may change addr in the following cycle.

Response:
- outstanding-- and pop the PC queue on every i_imem_rsp_valid.
- If drop_cnt>0: discard the response, drop_cnt--.
- Otherwise push {popped pc, data} into the output buffer.
- Response-to-o_valid latency is exactly 1 cycle; no combinational bypass.

Output:
- o_valid = buffer not empty; o_instr/o_pc = buffer head.
- Pop on o_valid & i_ready.
- Push and pop in the same cycle are both allowed, occupancy unchanged.

Redirect (i_b_taken=1), higher priority than everything else in that cycle:
- fetch_pc ← {i_b_pc[31:2],2'b00}.
- Output buffer flushed, and any push in the same cycle is discarded.
- drop_cnt ← outstanding after this edge, including a request accepted this cycle and excluding a response received this cycle.
- A simultaneous decode pop is ignored; o_valid=0 next cycle.
- o_misaligned=1 for exactly the next cycle when i_b_pc[1:0]!=0.
- First correct-path request is issued the cycle after the redirect, if credits allow.
- Back-to-back redirects: the last one wins.

Invariants (assertions):
- outstanding ≤ BUF_DEPTH.
- drop_cnt ≤ outstanding.
- Response with outstanding==0 is a protocol error and is flagged in simulation.

Test Plan:
- Reset release, memory ready=1, response latency 1, i_ready=1 → requests at 0x0,0x4,0x8…; first o_valid two cycles after first accept with o_pc=0x0; then one instruction per cycle sustained, zero bubbles.
- i_ready=0 for 5 cycles → at most BUF_DEPTH=2 outstanding+buffered; o_imem_req_valid drops to 0; buffer holds pc 0x0,0x4; on i_ready=1 drained in order, fetch resumes at 0x8.
- Response latency 3, redirect b_taken=1,b_pc=0x100 with 2 outstanding → both stale responses discarded (never o_valid); next request addr=0x100; first output o_pc=0x100.
- Redirect with b_pc=0x102 → o_misaligned pulse 1 cycle; fetch address 0x100.
- Redirect in same cycle as request handshake at 0x20 and buffer pop → that request dropped; o_valid=0 next cycle; no instruction from 0x20 or later delivered before target.
- Two redirects on consecutive cycles (0x200 then 0x300) while in S_DRAIN → only 0x300 stream delivered; drop_cnt correctly covers all stale responses.
- fetch_pc=0xFFFF_FFFC sequential → next request 0x0000_0000.
- i_rst_n asserted mid-fetch → all outputs at reset values immediately (async); after release, first request to RESET_PC.

Source files
------------

// File: rtl/fetch_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit_if
// Brief    : Bundles the fetch unit's instruction-memory request/response
//            channel, branch redirect inputs and decode hand-off signals.
//            master = fetch unit side, slave = memory/branch/decode side.
// Revision : 1.0 - initial release
// ============================================================================
interface fetch_unit_if;
    logic        o_imem_req_valid;
    logic        i_imem_req_ready;
    logic [31:0] o_imem_req_addr;
    logic        i_imem_rsp_valid;
    logic [31:0] i_imem_rsp_data;
    logic        i_b_taken;
    logic [31:0] i_b_pc;
    logic        o_valid;
    logic [31:0] o_instr;
    logic [31:0] o_pc;
    logic        i_ready;
    logic        o_misaligned;

    modport master (
        output o_imem_req_valid,
        input  i_imem_req_ready,
        output o_imem_req_addr,
        input  i_imem_rsp_valid,
        input  i_imem_rsp_data,
        input  i_b_taken,
        input  i_b_pc,
        output o_valid,
        output o_instr,
        output o_pc,
        input  i_ready,
        output o_misaligned
    );

    modport slave (
        input  o_imem_req_valid,
        output i_imem_req_ready,
        input  o_imem_req_addr,
        output i_imem_rsp_valid,
        output i_imem_rsp_data,
        output i_b_taken,
        output i_b_pc,
        input  o_valid,
        input  o_instr,
        input  o_pc,
        output i_ready,
        input  o_misaligned
    );
endinterface
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Brief    : Instruction-fetch front end. Issues sequential fetch requests
//            under a credit limit, tracks in-flight PCs, buffers in-order
//            responses for decode and squashes wrong-path fetches on a
//            branch redirect.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    fetch_unit_if.master  bus
);

    localparam int                 c_ptr_w     = $clog2(BUF_DEPTH);
    localparam int                 c_cnt_w     = c_ptr_w + 1;
    localparam logic [c_cnt_w-1:0] c_depth     = c_cnt_w'(BUF_DEPTH);
    localparam logic [c_cnt_w:0]   c_depth_ext = (c_cnt_w + 1)'(BUF_DEPTH);
    localparam logic [31:0]        c_nop       = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic [31:0]         r_fetch_pc;
    logic [c_cnt_w-1:0]  r_outstanding;
    logic [c_cnt_w-1:0]  r_drop_cnt;
    logic                r_misaligned;

    // In-flight PC queue: one entry per accepted request, popped per response
    logic [31:0]         r_pq_mem [BUF_DEPTH];
    logic [c_ptr_w-1:0]  r_pq_wr;
    logic [c_ptr_w-1:0]  r_pq_rd;

    // Output buffer toward decode
    logic [31:0]         r_ob_pc    [BUF_DEPTH];
    logic [31:0]         r_ob_instr [BUF_DEPTH];
    logic [c_ptr_w-1:0]  r_ob_wr;
    logic [c_ptr_w-1:0]  r_ob_rd;
    logic [c_cnt_w-1:0]  r_ob_cnt;

    logic                w_credit;
    logic                w_req_valid;
    logic                w_req_fire;
    logic [c_cnt_w-1:0]  w_out_nxt;
    logic [c_cnt_w-1:0]  w_drop_nxt;
    logic                w_ob_valid;
    logic                w_push;
    logic                w_pop;

    // Credits cover both requests in flight and instructions already buffered,
    // so every response is guaranteed a buffer slot.
    assign w_credit   = ({1'b0, r_outstanding} + {1'b0, r_ob_cnt}) < c_depth_ext;
    assign w_ob_valid = (r_ob_cnt != '0);
    // A redirect in the same cycle discards both the incoming push and the decode pop.
    assign w_push     = bus.i_imem_rsp_valid && (r_drop_cnt == '0) && !bus.i_b_taken;
    assign w_pop      = w_ob_valid && bus.i_ready && !bus.i_b_taken;

    // Next-state, request qualification and drop/outstanding bookkeeping
    always_comb begin
        w_state_nxt = r_state;
        w_req_valid = 1'b0;
        w_req_fire  = 1'b0;
        w_out_nxt   = r_outstanding;
        w_drop_nxt  = r_drop_cnt;

        w_req_valid = (r_state != S_BOOT) && w_credit;
        w_req_fire  = w_req_valid && bus.i_imem_req_ready;
        w_out_nxt   = r_outstanding + c_cnt_w'(w_req_fire) - c_cnt_w'(bus.i_imem_rsp_valid);

        // On redirect every request still outstanding after this edge is stale.
        if (bus.i_b_taken) begin
            w_drop_nxt = w_out_nxt;
        end else if (bus.i_imem_rsp_valid && (r_drop_cnt != '0)) begin
            w_drop_nxt = r_drop_cnt - c_cnt_w'(1);
        end

        case (r_state)
            S_BOOT:         w_state_nxt = S_RUN;
            S_RUN, S_DRAIN: w_state_nxt = (w_drop_nxt != '0) ? S_DRAIN : S_RUN;
            default:        w_state_nxt = S_BOOT;
        endcase
    end

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_BOOT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Fetch PC, counters, queue pointers and misalignment pulse
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_fetch_pc    <= RESET_PC;
            r_outstanding <= '0;
            r_drop_cnt    <= '0;
            r_misaligned  <= 1'b0;
            r_pq_wr       <= '0;
            r_pq_rd       <= '0;
            r_ob_wr       <= '0;
            r_ob_rd       <= '0;
            r_ob_cnt      <= '0;
        end else begin
            r_outstanding <= w_out_nxt;
            r_drop_cnt    <= w_drop_nxt;
            r_misaligned  <= bus.i_b_taken && (bus.i_b_pc[1:0] != 2'b00);

            if (bus.i_b_taken) begin
                r_fetch_pc <= {bus.i_b_pc[31:2], 2'b00};
            end else if (w_req_fire) begin
                r_fetch_pc <= r_fetch_pc + 32'd4;
            end

            if (w_req_fire) begin
                r_pq_wr <= r_pq_wr + c_ptr_w'(1);
            end
            if (bus.i_imem_rsp_valid) begin
                r_pq_rd <= r_pq_rd + c_ptr_w'(1);
            end

            if (bus.i_b_taken) begin
                r_ob_wr  <= '0;
                r_ob_rd  <= '0;
                r_ob_cnt <= '0;
            end else begin
                if (w_push) begin
                    r_ob_wr <= r_ob_wr + c_ptr_w'(1);
                end
                if (w_pop) begin
                    r_ob_rd <= r_ob_rd + c_ptr_w'(1);
                end
                r_ob_cnt <= r_ob_cnt + c_cnt_w'(w_push) - c_cnt_w'(w_pop);
            end
        end
    end

    // Queue storage; contents are don't-care until written, so no reset
    always_ff @(posedge i_clk) begin
        if (w_req_fire) begin
            r_pq_mem[r_pq_wr] <= r_fetch_pc;
        end
        if (w_push) begin
            r_ob_pc[r_ob_wr]    <= r_pq_mem[r_pq_rd];
            r_ob_instr[r_ob_wr] <= bus.i_imem_rsp_data;
        end
    end

    // Structural invariants and memory protocol check
    always_ff @(posedge i_clk) begin
        if (i_rst_n) begin
            assert (r_outstanding <= c_depth);
            assert (r_drop_cnt <= r_outstanding);
            if (bus.i_imem_rsp_valid) begin
                assert (r_outstanding != '0);
            end
        end
    end

    assign bus.o_imem_req_valid = w_req_valid;
    assign bus.o_imem_req_addr  = r_fetch_pc;
    assign bus.o_valid          = w_ob_valid;
    assign bus.o_instr          = w_ob_valid ? r_ob_instr[r_ob_rd] : c_nop;
    assign bus.o_pc             = w_ob_valid ? r_ob_pc[r_ob_rd] : 32'h0000_0000;
    assign bus.o_misaligned     = r_misaligned;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_unit
// Brief    : Self-checking bench for fetch_unit. An instruction memory model
//            returns ~addr as the instruction word; expected decode streams
//            are queued when stimulus is applied and a monitor compares every
//            instruction decode accepts.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

    logic clk;
    logic rst_n;

    fetch_unit_if bus ();

    fetch_unit #(
        .RESET_PC  (32'h0000_0000),
        .BUF_DEPTH (2)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mem_t;

    int          checks;
    int          errors;
    int          delivered;
    int          lat;
    int          cyc;
    logic [31:0] exp_q [$];
    mem_t        mq [$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    task automatic expect_stream(input logic [31:0] start);
        exp_q.delete();
        for (int i = 0; i < 100; i++) begin
            exp_q.push_back(start + 32'(4 * i));
        end
    endtask

    task automatic wait_delivered(input int n, input string name);
        int d0 = delivered;
        int i  = 0;
        while ((delivered - d0 < n) && (i < 200)) begin
            @(posedge clk);
            i++;
        end
        checks++;
        if (delivered - d0 < n) begin
            errors++;
            $display("FAIL %s: delivered %0d required %0d", name, delivered - d0, n);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: condition never reached, required within budget", name);
    endtask

    // Instruction memory: in-order responses, latency lat cycles after acceptance
    initial begin
        logic        fire_s;
        logic        rsp_s;
        logic [31:0] addr_s;
        cyc = 0;
        bus.i_imem_rsp_valid = 1'b0;
        bus.i_imem_rsp_data  = 32'h0;
        forever begin
            @(negedge clk);
            fire_s = bus.o_imem_req_valid && bus.i_imem_req_ready;
            rsp_s  = bus.i_imem_rsp_valid;
            addr_s = bus.o_imem_req_addr;
            @(posedge clk);
            #1;
            cyc++;
            if (!rst_n) begin
                mq.delete();
                bus.i_imem_rsp_valid = 1'b0;
            end else begin
                if (rsp_s && (mq.size() > 0)) begin
                    void'(mq.pop_front());
                end
                if (fire_s) begin
                    mq.push_back('{addr: addr_s, due: cyc + lat - 1});
                end
                if ((mq.size() > 0) && (mq[0].due <= cyc)) begin
                    bus.i_imem_rsp_valid = 1'b1;
                    bus.i_imem_rsp_data  = ~mq[0].addr;
                end else begin
                    bus.i_imem_rsp_valid = 1'b0;
                    bus.i_imem_rsp_data  = 32'h0;
                end
            end
        end
    end

    // Monitor: compare every instruction decode accepts against the expected stream
    initial begin
        logic [31:0] e;
        delivered = 0;
        forever begin
            @(negedge clk);
            if (rst_n && bus.o_valid && bus.i_ready && !bus.i_b_taken) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_out: got pc %h required no output", bus.o_pc);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_pc", bus.o_pc, e);
                    chk("out_instr", bus.o_instr, ~e);
                    delivered++;
                end
            end
        end
    end

    // Watchdog
    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1);
    end

    // Directed stimulus
    initial begin
        bit found;
        checks = 0;
        errors = 0;
        lat    = 1;
        rst_n  = 1'b0;
        bus.i_imem_req_ready = 1'b1;
        bus.i_b_taken        = 1'b0;
        bus.i_b_pc           = 32'h0;
        bus.i_ready          = 1'b0;
        repeat (3) @(posedge clk);

        // Reset values
        @(negedge clk);
        chk("rst_req_valid", {31'b0, bus.o_imem_req_valid}, 32'd0);
        chk("rst_o_valid", {31'b0, bus.o_valid}, 32'd0);
        chk("rst_o_instr", bus.o_instr, 32'h13);
        chk("rst_o_pc", bus.o_pc, 32'h0);
        chk("rst_misaligned", {31'b0, bus.o_misaligned}, 32'd0);

        // Boot cycle, first request, first-valid latency; decode stalled
        expect_stream(32'h0);
        rst_n = 1'b1;
        #1;
        chk("boot_no_req", {31'b0, bus.o_imem_req_valid}, 32'd0);
        @(negedge clk);
        chk("first_req_valid", {31'b0, bus.o_imem_req_valid}, 32'd1);
        chk("first_req_addr", bus.o_imem_req_addr, 32'h0);
        @(negedge clk);
        chk("valid_not_early", {31'b0, bus.o_valid}, 32'd0);
        @(negedge clk);
        chk("first_valid", {31'b0, bus.o_valid}, 32'd1);
        chk("first_pc", bus.o_pc, 32'h0);

        // Stall: credits exhausted, buffer holds 0x0/0x4, fetch parked at 0x8
        repeat (5) @(negedge clk);
        chk("stall_req_valid", {31'b0, bus.o_imem_req_valid}, 32'd0);
        chk("stall_head_pc", bus.o_pc, 32'h0);
        chk("stall_fetch_addr", bus.o_imem_req_addr, 32'h8);
        @(posedge clk);
        #1;
        bus.i_ready = 1'b1;
        wait_delivered(12, "seq_stream");

        // Redirect to 0x100 with two requests in flight at latency 3
        lat = 3;
        found = 0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk);
            #2;
            if (mq.size() == 2) begin
                found = 1;
                break;
            end
        end
        if (!found) timeout_fail("two_outstanding");
        bus.i_b_taken = 1'b1;
        bus.i_b_pc    = 32'h100;
        expect_stream(32'h100);
        @(posedge clk);
        #1;
        bus.i_b_taken = 1'b0;
        @(negedge clk);
        chk("redir_addr", bus.o_imem_req_addr, 32'h100);
        chk("redir_no_valid", {31'b0, bus.o_valid}, 32'd0);
        chk("redir_aligned", {31'b0, bus.o_misaligned}, 32'd0);
        wait_delivered(4, "redir_100_stream");

        // Misaligned target
        @(posedge clk);
        #2;
        bus.i_b_taken = 1'b1;
        bus.i_b_pc    = 32'h102;
        expect_stream(32'h100);
        @(posedge clk);
        #1;
        bus.i_b_taken = 1'b0;
        @(negedge clk);
        chk("misaligned_pulse", {31'b0, bus.o_misaligned}, 32'd1);
        chk("misaligned_addr", bus.o_imem_req_addr, 32'h100);
        @(negedge clk);
        chk("misaligned_end", {31'b0, bus.o_misaligned}, 32'd0);
        wait_delivered(4, "misaligned_stream");

        // Redirect coinciding with a request handshake and a decode pop
        lat = 1;
        found = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.o_imem_req_valid && bus.i_imem_req_ready && bus.o_valid && bus.i_ready) begin
                found = 1;
                break;
            end
        end
        if (!found) timeout_fail("fire_and_pop");
        bus.i_b_taken = 1'b1;
        bus.i_b_pc    = 32'h400;
        expect_stream(32'h400);
        @(posedge clk);
        #1;
        bus.i_b_taken = 1'b0;
        @(negedge clk);
        chk("pop_ignored_valid", {31'b0, bus.o_valid}, 32'd0);
        chk("pop_ignored_addr", bus.o_imem_req_addr, 32'h400);
        wait_delivered(4, "redir_400_stream");

        // Back-to-back redirects while draining: last one wins
        lat = 3;
        found = 0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk);
            #2;
            if (mq.size() > 0) begin
                found = 1;
                break;
            end
        end
        if (!found) timeout_fail("drain_entry");
        bus.i_b_taken = 1'b1;
        bus.i_b_pc    = 32'h200;
        expect_stream(32'h200);
        @(posedge clk);
        #1;
        bus.i_b_pc    = 32'h300;
        expect_stream(32'h300);
        @(posedge clk);
        #1;
        bus.i_b_taken = 1'b0;
        @(negedge clk);
        chk("b2b_addr", bus.o_imem_req_addr, 32'h300);
        wait_delivered(5, "redir_300_stream");

        // Address wrap past 0xFFFF_FFFC
        lat = 1;
        @(posedge clk);
        #2;
        bus.i_b_taken = 1'b1;
        bus.i_b_pc    = 32'hFFFF_FFF8;
        expect_stream(32'hFFFF_FFF8);
        @(posedge clk);
        #1;
        bus.i_b_taken = 1'b0;
        wait_delivered(5, "wrap_stream");

        // Asynchronous reset mid-fetch
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_req_valid", {31'b0, bus.o_imem_req_valid}, 32'd0);
        chk("async_o_valid", {31'b0, bus.o_valid}, 32'd0);
        chk("async_o_instr", bus.o_instr, 32'h13);
        chk("async_o_pc", bus.o_pc, 32'h0);
        chk("async_misaligned", {31'b0, bus.o_misaligned}, 32'd0);
        expect_stream(32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("reboot_no_req", {31'b0, bus.o_imem_req_valid}, 32'd0);
        @(negedge clk);
        chk("reboot_req_valid", {31'b0, bus.o_imem_req_valid}, 32'd1);
        chk("reboot_req_addr", bus.o_imem_req_addr, 32'h0);
        wait_delivered(4, "reboot_stream");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
